decode_stage_ps: RTL and testbench

Parametrised decode stage with an internal register file, load-use hazard detection, bubble insertion, flush and hold. It sits between fetch and execute and decodes one 16-bit instruction per cycle. It reads operands from an 8-entry register file written back from WB, and registers controls, operands and the immediate into the ID/EX pipeline register. It adds data-width generality, a valid bit, stall/flush/hold control, WB-to-ID bypass, illegal-opcode flagging and a stall counter.

---
 rtl/decode_stage_ps.sv | 223 ++++++++++++++++++++++
 tb/tb_decode_stage_ps.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_ps.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage_ps
// Purpose  : Pipeline decode stage. Decodes one 16-bit instruction per
//            cycle, reads operands from an 8-entry register file written back
//            from WB (with same-cycle WB bypass), detects load-use hazards and
//            inserts one bubble per dependency, and registers controls,
//            operands and the sign-extended immediate into ID/EX.
// Ports    : clk, rst                      - clock, synchronous active-high reset
//            instr_valid, instruction      - fetched instruction and its qualifier
//            flush, hold                   - kill decode / freeze ID/EX
//            wb_reg_write, wb_addr, wb_data- register-file write port
//            stall_out                     - combinational fetch stall
//            valid_r .. illegal_r          - registered ID/EX controls
//            read_data1_r, read_data2_r,
//            imm_r, rd_r                   - registered operands / destination
//            stall_count                   - saturating hazard-bubble count
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage_ps #(
   parameter int WIDTH = 16,
   parameter int IMM_W = 7,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             instr_valid,
   input  logic [15:0]      instruction,
   input  logic             flush,
   input  logic             hold,
   input  logic             wb_reg_write,
   input  logic [2:0]       wb_addr,
   input  logic [WIDTH-1:0] wb_data,
   output logic             stall_out,
   output logic             valid_r,
   output logic [1:0]       ALUOp_r,
   output logic [1:0]       carrySelect_r,
   output logic             WB_ALUtoReg_r,
   output logic             RegWrite_r,
   output logic             MemRead_r,
   output logic             MemWrite_r,
   output logic             alu_src_imm_r,
   output logic             illegal_r,
   output logic [WIDTH-1:0] read_data1_r,
   output logic [WIDTH-1:0] read_data2_r,
   output logic [WIDTH-1:0] imm_r,
   output logic [2:0]       rd_r,
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [0:0] c_ST_RUN    = 1'b0;
   localparam logic [0:0] c_ST_BUBBLE = 1'b1;

   localparam logic [2:0] c_OP_NOP   = 3'b000;
   localparam logic [2:0] c_OP_ALUR  = 3'b001;
   localparam logic [2:0] c_OP_ADDI  = 3'b010;
   localparam logic [2:0] c_OP_LOAD  = 3'b011;
   localparam logic [2:0] c_OP_STORE = 3'b100;
   localparam logic [2:0] c_OP_CARRY = 3'b101;

   // ID/EX contents; an all-zero value is the bubble.
   typedef struct packed {
      logic             valid;
      logic [1:0]       aluop;
      logic [1:0]       carry;
      logic             wb_alu;
      logic             reg_write;
      logic             mem_read;
      logic             mem_write;
      logic             alu_src_imm;
      logic             illegal;
      logic [WIDTH-1:0] rd1;
      logic [WIDTH-1:0] rd2;
      logic [WIDTH-1:0] imm;
      logic [2:0]       rd;
   } idex_t;

   idex_t            idex_q, idex_d;
   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] rf_q [8];

   logic [2:0]       w_opcode, w_rs1_addr, w_rs2_addr;
   logic [WIDTH-1:0] w_rd1, w_rd2, w_imm;
   logic             w_use_rs1, w_use_rs2;
   logic             w_hazard, w_hazard_stall, w_count_en;
   idex_t            w_dec;

   assign w_opcode   = instruction[15:13];
   assign w_rs1_addr = instruction[12:10];
   assign w_rs2_addr = instruction[9:7];
   assign w_imm      = {{(WIDTH-IMM_W){instruction[IMM_W-1]}}, instruction[IMM_W-1:0]};

   // A WB write in the same cycle is forwarded so decode never sees stale data.
   assign w_rd1 = (wb_reg_write && (wb_addr == w_rs1_addr)) ? wb_data : rf_q[w_rs1_addr];
   assign w_rd2 = (wb_reg_write && (wb_addr == w_rs2_addr)) ? wb_data : rf_q[w_rs2_addr];

   // Register file: writes are unconditional w.r.t. flush/hold/stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) rf_q[i] <= '0;
      end else if (wb_reg_write) begin
         rf_q[wb_addr] <= wb_data;
      end
   end

   // Instruction decode; also reports which source fields the opcode reads.
   always_comb begin
      w_dec       = '0;
      w_use_rs1   = 1'b0;
      w_use_rs2   = 1'b0;
      w_dec.valid = 1'b1;
      w_dec.rd1   = w_rd1;
      w_dec.rd2   = w_rd2;
      w_dec.imm   = w_imm;
      w_dec.rd    = w_rs1_addr;
      case (w_opcode)
         c_OP_NOP: ;
         c_OP_ALUR: begin
            w_dec.aluop     = instruction[1:0];
            w_dec.carry     = instruction[3:2];
            w_dec.reg_write = 1'b1;
            w_dec.wb_alu    = 1'b1;
            w_use_rs1       = 1'b1;
            w_use_rs2       = 1'b1;
         end
         c_OP_ADDI: begin
            w_dec.alu_src_imm = 1'b1;
            w_dec.reg_write   = 1'b1;
            w_dec.wb_alu      = 1'b1;
            w_use_rs1         = 1'b1;
         end
         c_OP_LOAD: begin
            w_dec.mem_read    = 1'b1;
            w_dec.reg_write   = 1'b1;
            w_dec.alu_src_imm = 1'b1;
            w_use_rs2         = 1'b1;
         end
         c_OP_STORE: begin
            w_dec.mem_write   = 1'b1;
            w_dec.alu_src_imm = 1'b1;
            w_use_rs1         = 1'b1;
            w_use_rs2         = 1'b1;
         end
         c_OP_CARRY: w_dec.carry = instruction[1:0];
         default:    w_dec.illegal = 1'b1;
      endcase
   end

   // Load in ID/EX whose destination is read by the instruction in decode.
   assign w_hazard = idex_q.valid & idex_q.mem_read & instr_valid &
                     ((w_use_rs1 & (idex_q.rd == w_rs1_addr)) |
                      (w_use_rs2 & (idex_q.rd == w_rs2_addr)));

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= c_ST_RUN;
      else     state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      if (flush)                                   state_d = c_ST_RUN;
      else if (hold)                               state_d = state_q;
      else if ((state_q == c_ST_RUN) && w_hazard)  state_d = c_ST_BUBBLE;
      else                                         state_d = c_ST_RUN;
   end

   // FSM: outputs. A bubble in ID/EX cannot be a load, so BUBBLE never stalls.
   always_comb begin
      stall_out      = 1'b0;
      w_hazard_stall = 1'b0;
      w_count_en     = 1'b0;
      if (!rst && !flush) begin
         if (hold) begin
            stall_out = 1'b1;
         end else if ((state_q == c_ST_RUN) && w_hazard) begin
            stall_out      = 1'b1;
            w_hazard_stall = 1'b1;
            w_count_en     = 1'b1;
         end
      end
   end

   // ID/EX next value: flush > hold > hazard bubble > idle bubble > decode.
   always_comb begin
      idex_d = idex_q;
      if (flush)                              idex_d = '0;
      else if (hold)                          idex_d = idex_q;
      else if (w_hazard_stall || !instr_valid) idex_d = '0;
      else                                    idex_d = w_dec;
   end

   always_ff @(posedge clk) begin
      if (rst) idex_q <= '0;
      else     idex_q <= idex_d;
   end

   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else if (w_count_en && (cnt_q != {CNT_W{1'b1}}))
         cnt_q <= cnt_q + 1'b1;
   end

   assign valid_r       = idex_q.valid;
   assign ALUOp_r       = idex_q.aluop;
   assign carrySelect_r = idex_q.carry;
   assign WB_ALUtoReg_r = idex_q.wb_alu;
   assign RegWrite_r    = idex_q.reg_write;
   assign MemRead_r     = idex_q.mem_read;
   assign MemWrite_r    = idex_q.mem_write;
   assign alu_src_imm_r = idex_q.alu_src_imm;
   assign illegal_r     = idex_q.illegal;
   assign read_data1_r  = idex_q.rd1;
   assign read_data2_r  = idex_q.rd2;
   assign imm_r         = idex_q.imm;
   assign rd_r          = idex_q.rd;
   assign stall_count   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_ps.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage_ps
// Purpose  : Directed scoreboard bench for decode_stage_ps (WIDTH=16,
//            IMM_W=7, CNT_W=4). The driver pushes hand-computed expectations
//            into two queues; independent monitors pop and compare stall_out
//            (mid-cycle) and the ID/EX outputs (after each rising edge).
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage_ps;

   typedef struct packed {
      logic [10:0] ctl;   // {valid, aluop, carry, wbalu, regw, memr, memw, isrc, ill}
      logic [15:0] rd1;
      logic [15:0] rd2;
      logic [15:0] imm;
      logic [2:0]  rd;
      logic [3:0]  cnt;
   } pkt_t;

   //                                        v  op cs wa rw mr mw is il
   localparam logic [10:0] K_LOAD   = 11'b1_00_00_0__1__1__0__1__0;
   localparam logic [10:0] K_ADDI   = 11'b1_00_00_1__1__0__0__1__0;
   localparam logic [10:0] K_STORE  = 11'b1_00_00_0__0__0__1__1__0;
   localparam logic [10:0] K_ALU00  = 11'b1_00_00_1__1__0__0__0__0;
   localparam logic [10:0] K_ALU01  = 11'b1_01_00_1__1__0__0__0__0;
   localparam logic [10:0] K_ALU21  = 11'b1_10_01_1__1__0__0__0__0;
   localparam logic [10:0] K_CARRY2 = 11'b1_00_10_0__0__0__0__0__0;
   localparam logic [10:0] K_ILL    = 11'b1_00_00_0__0__0__0__0__1;

   logic        clk = 1'b0;
   logic        rst, instr_valid, flush, hold, wb_reg_write;
   logic [15:0] instruction, wb_data;
   logic [2:0]  wb_addr;
   logic        stall_out, valid_r, WB_ALUtoReg_r, RegWrite_r, MemRead_r, MemWrite_r;
   logic        alu_src_imm_r, illegal_r;
   logic [1:0]  ALUOp_r, carrySelect_r;
   logic [15:0] read_data1_r, read_data2_r, imm_r;
   logic [2:0]  rd_r;
   logic [3:0]  stall_count;

   pkt_t q_out[$];
   logic q_stall[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   out_idx = 0;
   int   st_idx  = 0;
   pkt_t mon_e, mon_g;
   logic st_e;

   always #5 clk = ~clk;

   decode_stage_ps #(.WIDTH(16), .IMM_W(7), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instruction(instruction),
      .flush(flush), .hold(hold), .wb_reg_write(wb_reg_write), .wb_addr(wb_addr),
      .wb_data(wb_data), .stall_out(stall_out), .valid_r(valid_r), .ALUOp_r(ALUOp_r),
      .carrySelect_r(carrySelect_r), .WB_ALUtoReg_r(WB_ALUtoReg_r),
      .RegWrite_r(RegWrite_r), .MemRead_r(MemRead_r), .MemWrite_r(MemWrite_r),
      .alu_src_imm_r(alu_src_imm_r), .illegal_r(illegal_r),
      .read_data1_r(read_data1_r), .read_data2_r(read_data2_r), .imm_r(imm_r),
      .rd_r(rd_r), .stall_count(stall_count)
   );

   function automatic logic [15:0] ins(input logic [2:0] op, input logic [2:0] a,
                                       input logic [2:0] b, input logic [6:0] lo);
      return {op, a, b, lo};
   endfunction

   function automatic pkt_t pk(input logic [10:0] ctl, input logic [15:0] a,
                               input logic [15:0] b, input logic [15:0] im,
                               input logic [2:0] d, input int c);
      pkt_t p;
      p.ctl = ctl; p.rd1 = a; p.rd2 = b; p.imm = im; p.rd = d; p.cnt = c[3:0];
      return p;
   endfunction

   function automatic pkt_t bub(input int c);
      return pk(11'b0, 16'h0, 16'h0, 16'h0, 3'd0, c);
   endfunction

   function automatic int sat(input int v);
      return (v > 15) ? 15 : v;
   endfunction

   // One cycle of stimulus: inputs applied at the falling edge, expectations queued.
   task automatic step(input logic r, input logic iv, input logic [15:0] in_w,
                       input logic fl, input logic hd, input logic ww,
                       input logic [2:0] wa, input logic [15:0] wd,
                       input logic st, input pkt_t e);
      @(negedge clk);
      rst = r; instr_valid = iv; instruction = in_w; flush = fl; hold = hd;
      wb_reg_write = ww; wb_addr = wa; wb_data = wd;
      q_stall.push_back(st);
      q_out.push_back(e);
   endtask

   task automatic run(input logic iv, input logic [15:0] in_w, input logic st, input pkt_t e);
      step(1'b0, iv, in_w, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, st, e);
   endtask

   // Monitor: stall_out is combinational, checked mid-cycle.
   always @(negedge clk) begin
      #1;
      if (q_stall.size() > 0) begin
         st_e = q_stall.pop_front();
         n_tests++;
         if (stall_out !== st_e) begin
            n_fail++;
            $display("FAIL stall[%0d] got stall_out=%b exp %b", st_idx, stall_out, st_e);
         end
         st_idx++;
      end
   end

   // Monitor: ID/EX outputs, checked just after each rising edge.
   always @(posedge clk) begin
      #1;
      if (q_out.size() > 0) begin
         mon_e = q_out.pop_front();
         mon_g = {valid_r, ALUOp_r, carrySelect_r, WB_ALUtoReg_r, RegWrite_r, MemRead_r,
                  MemWrite_r, alu_src_imm_r, illegal_r, read_data1_r, read_data2_r,
                  imm_r, rd_r, stall_count};
         n_tests++;
         if (mon_g !== mon_e) begin
            n_fail++;
            $display("FAIL out[%0d] got ctl=%b d1=%h d2=%h imm=%h rd=%0d cnt=%0d exp ctl=%b d1=%h d2=%h imm=%h rd=%0d cnt=%0d",
                     out_idx, mon_g.ctl, mon_g.rd1, mon_g.rd2, mon_g.imm, mon_g.rd, mon_g.cnt,
                     mon_e.ctl, mon_e.rd1, mon_e.rd2, mon_e.imm, mon_e.rd, mon_e.cnt);
         end
         out_idx++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; instr_valid = 1'b0; instruction = 16'h0; flush = 1'b0; hold = 1'b0;
      wb_reg_write = 1'b0; wb_addr = 3'd0; wb_data = 16'h0;

      // Reset for two cycles
      step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, bub(0));
      step(1'b1, 1'b1, ins(3'b011, 3'd1, 3'd2, 7'h0), 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, bub(0));
      // ALU-R reading r3 after reset
      run(1'b1, ins(3'b001, 3'd3, 3'd0, 7'h00), 1'b0, pk(K_ALU00, 16'h0, 16'h0, 16'h0, 3'd3, 0));
      // WB r2=0x1234 bypassed into ALU-R rs1=r2, ALUOp=2 carry=1
      step(1'b0, 1'b1, ins(3'b001, 3'd2, 3'd0, 7'h06), 1'b0, 1'b0, 1'b1, 3'd2, 16'h1234,
           1'b0, pk(K_ALU21, 16'h1234, 16'h0, 16'h0006, 3'd2, 0));
      // LOAD rd=r5 base r2, with WB r5=0x00A5 bypassed into rs1 field
      step(1'b0, 1'b1, ins(3'b011, 3'd5, 3'd2, 7'h03), 1'b0, 1'b0, 1'b1, 3'd5, 16'h00A5,
           1'b0, pk(K_LOAD, 16'h00A5, 16'h1234, 16'h0003, 3'd5, 0));
      // Load-use on rs2=r5: one bubble, then ALU-R
      run(1'b1, ins(3'b001, 3'd1, 3'd5, 7'h01), 1'b1, bub(1));
      run(1'b1, ins(3'b001, 3'd1, 3'd5, 7'h01), 1'b0, pk(K_ALU01, 16'h0, 16'h00A5, 16'h0001, 3'd1, 1));
      // LOAD r4 then independent ADDI r1 (rs2 field = r4 is unused), imm 0x7F
      run(1'b1, ins(3'b011, 3'd4, 3'd2, 7'h10), 1'b0, pk(K_LOAD, 16'h0, 16'h1234, 16'h0010, 3'd4, 1));
      run(1'b1, ins(3'b010, 3'd1, 3'd4, 7'h7F), 1'b0, pk(K_ADDI, 16'h0, 16'h0, 16'hFFFF, 3'd1, 1));
      // Back-to-back dependent loads, then dependent ALU-R
      run(1'b1, ins(3'b011, 3'd6, 3'd2, 7'h00), 1'b0, pk(K_LOAD, 16'h0, 16'h1234, 16'h0, 3'd6, 1));
      run(1'b1, ins(3'b011, 3'd7, 3'd6, 7'h00), 1'b1, bub(2));
      run(1'b1, ins(3'b011, 3'd7, 3'd6, 7'h00), 1'b0, pk(K_LOAD, 16'h0, 16'h0, 16'h0, 3'd7, 2));
      run(1'b1, ins(3'b001, 3'd7, 3'd0, 7'h00), 1'b1, bub(3));
      run(1'b1, ins(3'b001, 3'd7, 3'd0, 7'h00), 1'b0, pk(K_ALU00, 16'h0, 16'h0, 16'h0, 3'd7, 3));
      // Flush overrides a hazard: bubble, no count
      run(1'b1, ins(3'b011, 3'd3, 3'd2, 7'h00), 1'b0, pk(K_LOAD, 16'h0, 16'h1234, 16'h0, 3'd3, 3));
      step(1'b0, 1'b1, ins(3'b100, 3'd3, 3'd0, 7'h05), 1'b1, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, bub(3));
      run(1'b1, ins(3'b100, 3'd3, 3'd0, 7'h05), 1'b0, pk(K_STORE, 16'h0, 16'h0, 16'h0005, 3'd3, 3));
      // Hold for 3 cycles (WB r1=0x0042 still lands), then CARRY decodes
      step(1'b0, 1'b1, ins(3'b101, 3'd1, 3'd0, 7'h02), 1'b0, 1'b1, 1'b1, 3'd1, 16'h0042,
           1'b1, pk(K_STORE, 16'h0, 16'h0, 16'h0005, 3'd3, 3));
      for (int k = 0; k < 2; k++)
         step(1'b0, 1'b1, ins(3'b101, 3'd1, 3'd0, 7'h02), 1'b0, 1'b1, 1'b0, 3'd0, 16'h0,
              1'b1, pk(K_STORE, 16'h0, 16'h0, 16'h0005, 3'd3, 3));
      run(1'b1, ins(3'b101, 3'd1, 3'd0, 7'h02), 1'b0, pk(K_CARRY2, 16'h0042, 16'h0, 16'h0002, 3'd1, 3));
      // Hold during a hazard: no count; released hazard then counts
      run(1'b1, ins(3'b011, 3'd1, 3'd0, 7'h00), 1'b0, pk(K_LOAD, 16'h0042, 16'h0, 16'h0, 3'd1, 3));
      step(1'b0, 1'b1, ins(3'b010, 3'd1, 3'd0, 7'h01), 1'b0, 1'b1, 1'b0, 3'd0, 16'h0,
           1'b1, pk(K_LOAD, 16'h0042, 16'h0, 16'h0, 3'd1, 3));
      run(1'b1, ins(3'b010, 3'd1, 3'd0, 7'h01), 1'b1, bub(4));
      run(1'b1, ins(3'b010, 3'd1, 3'd0, 7'h01), 1'b0, pk(K_ADDI, 16'h0042, 16'h0, 16'h0001, 3'd1, 4));
      // Illegal opcodes 111 and 110
      run(1'b1, ins(3'b111, 3'd2, 3'd0, 7'h00), 1'b0, pk(K_ILL, 16'h1234, 16'h0, 16'h0, 3'd2, 4));
      run(1'b1, ins(3'b110, 3'd0, 3'd2, 7'h05), 1'b0, pk(K_ILL, 16'h0, 16'h1234, 16'h0005, 3'd0, 4));
      // instr_valid=0 behind a load: bubble, no stall
      run(1'b1, ins(3'b011, 3'd5, 3'd0, 7'h00), 1'b0, pk(K_LOAD, 16'h00A5, 16'h0, 16'h0, 3'd5, 4));
      run(1'b0, ins(3'b001, 3'd1, 3'd5, 7'h00), 1'b0, bub(4));
      // Reset arriving in BUBBLE
      run(1'b1, ins(3'b011, 3'd5, 3'd0, 7'h00), 1'b0, pk(K_LOAD, 16'h00A5, 16'h0, 16'h0, 3'd5, 4));
      run(1'b1, ins(3'b001, 3'd2, 3'd5, 7'h00), 1'b1, bub(5));
      step(1'b1, 1'b1, ins(3'b001, 3'd2, 3'd5, 7'h00), 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, bub(0));
      run(1'b1, ins(3'b001, 3'd2, 3'd5, 7'h00), 1'b0, pk(K_ALU00, 16'h0, 16'h0, 16'h0, 3'd2, 0));
      // 20 hazards: counter saturates at 0xF
      for (int i = 1; i <= 20; i++) begin
         run(1'b1, ins(3'b011, 3'd1, 3'd0, 7'h00), 1'b0, pk(K_LOAD, 16'h0, 16'h0, 16'h0, 3'd1, sat(i - 1)));
         run(1'b1, ins(3'b001, 3'd1, 3'd0, 7'h00), 1'b1, bub(sat(i)));
         run(1'b1, ins(3'b001, 3'd1, 3'd0, 7'h00), 1'b0, pk(K_ALU00, 16'h0, 16'h0, 16'h0, 3'd1, sat(i)));
      end
      run(1'b0, 16'h0, 1'b0, bub(15));

      repeat (3) @(posedge clk);
      #2;
      n_tests++;
      if ((q_out.size() != 0) || (q_stall.size() != 0)) begin
         n_fail++;
         $display("FAIL drain got out=%0d stall=%0d pending exp 0", q_out.size(), q_stall.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
